instr_fetch_unit: RTL and testbench

- Fetch stage placed in front of the mini-MIPS decode/execute datapath.
- Replaces the hardcoded combinational instruction array with a request/acknowledge instruction-memory port that tolerates variable latency.
- Buffers fetched 16-bit instructions in a small prefetch queue and hands {ir, pc} pairs to decode over a valid/ready handshake.
- Supports pc redirect (branch/jump) with queue flush.

---
 rtl/instr_fetch_unit.sv | 198 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage for the mini-MIPS pipeline. It issues requests to an
// instruction memory whose latency may vary, keeps fetched 16-bit words in a
// small prefetch queue and hands {ir, pc} pairs to decode.
//
// Handshakes (valid/ready semantics, used on both sides):
//   mem_req/mem_ack : once mem_req rises, mem_req and mem_addr hold steady
//                     until the rising edge where mem_ack is sampled high.
//                     mem_rdata is valid only in that cycle.
//   ir_valid/ir_ready : the head entry transfers at a rising edge where both
//                     are high. ir_ready with ir_valid low does nothing.
//                     ir/pc hold steady while ir_valid is high and not taken.
//   redirect        : outranks everything. It empties the queue, drops any
//                     pending or same-cycle fetch data and restarts fetch at
//                     redirect_pc with bit 0 forced to 0.
//
// Parameters:
//   DEPTH    : prefetch queue entries (power of 2, at least 2)
//   RESET_PC : byte address of the first fetch after reset (bit 0 = 0)
//
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   mem_req, mem_addr       : instruction-memory request and byte address
//   mem_ack, mem_rdata      : memory completion and instruction word
//   ir_valid, ir_ready      : decode handshake for the queue head
//   ir, pc                  : head instruction and its byte address
//   redirect, redirect_pc   : branch/jump restart
//   queue_count             : occupied queue entries
//   halted                  : fetch stopped on a HALT opcode
//   fsm_state               : debug view of the fetch FSM (0 IDLE, 1 REQ, 2 DRAIN)
//
// Optional build macro INSTR_FETCH_HALT_DETECT_EN: a pushed word with opcode
// 4'b1111 stops new requests until redirect or reset. Without the macro that
// opcode is an ordinary instruction and halted is tied low.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic                      mem_req,
   output logic [15:0]               mem_addr,
   input  logic                      mem_ack,
   input  logic [15:0]               mem_rdata,
   output logic                      ir_valid,
   input  logic                      ir_ready,
   output logic [15:0]               ir,
   output logic [15:0]               pc,
   input  logic                      redirect,
   input  logic [15:0]               redirect_pc,
   output logic [$clog2(DEPTH):0]    queue_count,
   output logic                      halted,
   output logic [1:0]                fsm_state
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // DRAIN doubles as the "drop the pending response" flag.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state, next_state;
   logic [15:0]   fetch_pc, next_fetch_pc, next_mem_addr, target_pc;
   logic [15:0]   ir_mem [DEPTH];
   logic [15:0]   pc_mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [CW:0]   count_after;
   logic          push, pop, halt_hit;

   assign target_pc = redirect_pc & 16'hFFFE;
   assign pop       = ir_valid && ir_ready;

   // Occupancy once this cycle's push and any pop have landed; the next
   // request may be issued only if this still leaves a free slot for it.
   assign count_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

`ifdef INSTR_FETCH_HALT_DETECT_EN
   assign halt_hit = push && (mem_rdata[15:12] == 4'b1111);

   always_ff @(posedge clock) begin
      if (reset) begin
         halted <= 1'b0;
      end else if (redirect) begin
         halted <= 1'b0;
      end else if (halt_hit) begin
         halted <= 1'b1;
      end
   end
`else
   assign halt_hit = 1'b0;
   assign halted   = 1'b0;
`endif

   always_comb begin
      next_state    = state;
      next_fetch_pc = fetch_pc;
      next_mem_addr = mem_addr;
      push          = 1'b0;
      case (state)
         IDLE: begin
            if (redirect) begin
               next_state    = REQ;
               next_fetch_pc = target_pc;
               next_mem_addr = target_pc;
            end else if (!halted && (count < CW'(DEPTH))) begin
               next_state    = REQ;
               next_mem_addr = fetch_pc;
            end
         end
         REQ: begin
            if (redirect) begin
               next_fetch_pc = target_pc;
               if (mem_ack) begin
                  // Response dropped; the new address goes out right away.
                  next_state    = REQ;
                  next_mem_addr = target_pc;
               end else begin
                  // Memory still owes a response; keep the request stable.
                  next_state = DRAIN;
               end
            end else if (mem_ack) begin
               push          = 1'b1;
               next_fetch_pc = fetch_pc + 16'd2;
               next_mem_addr = fetch_pc + 16'd2;
               if (!halt_hit && (count_after < (CW+1)'(DEPTH))) begin
                  next_state = REQ;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         DRAIN: begin
            if (redirect) begin
               next_fetch_pc = target_pc;
            end
            if (mem_ack) begin
               next_state    = REQ;
               next_mem_addr = redirect ? target_pc : fetch_pc;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         mem_addr <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         state    <= next_state;
         fetch_pc <= next_fetch_pc;
         mem_addr <= next_mem_addr;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Queue storage needs no reset: count gates every read.
   always_ff @(posedge clock) begin
      if (push) begin
         ir_mem[wr_ptr] <= mem_rdata;
         pc_mem[wr_ptr] <= mem_addr;
      end
   end

   assign mem_req     = (state != IDLE);
   assign ir_valid    = (count != '0);
   assign ir          = ir_mem[rd_ptr];
   assign pc          = pc_mem[rd_ptr];
   assign queue_count = count;
   assign fsm_state   = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. A behavioural instruction memory answers after
// mem_wait extra cycles. Expected {ir, pc} pairs are queued from the memory
// contents when a scenario starts, and a negedge monitor pops and compares
// them as decode takes entries. Inputs change 1 time unit after the rising
// edge and direct checks are made at that point.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clock;
   logic        reset;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        ir_valid;
   logic        ir_ready;
   logic [15:0] ir;
   logic [15:0] pc;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [2:0]  queue_count;
   logic        halted;
   logic [1:0]  fsm_state;

   int          checks;
   int          errors;
   int          mem_wait;
   int          wait_cnt;
   logic        halt_word_en;
   logic        sb_en;
   logic [31:0] exp_q[$];
   logic [15:0] ack_log[$];

   instr_fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clock       (clock),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .ir_valid    (ir_valid),
      .ir_ready    (ir_ready),
      .ir          (ir),
      .pc          (pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .queue_count (queue_count),
      .halted      (halted),
      .fsm_state   (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   // ---------------- memory model ----------------
   function automatic logic [15:0] word_at(input logic [15:0] addr, input logic halt_en);
      logic [15:0] w;
      case (addr)
         16'h0000: w = 16'h710F;
         16'h0002: w = 16'h7207;
         16'h0004: w = 16'h0312;
         16'h0006: w = 16'h1423;
         16'h0008: w = 16'h2534;
         16'h000A: w = 16'h3645;
         16'h000C: w = 16'h4756;
         16'h000E: w = 16'h5867;
         16'h0010: w = 16'h6978;
         default:  w = {1'b0, addr[15:1]} ^ 16'h1234;
      endcase
      if (halt_en && addr == 16'h0004) w = 16'hF000;
      return w;
   endfunction

   assign mem_ack   = mem_req && (wait_cnt == mem_wait);
   assign mem_rdata = word_at(mem_addr, halt_word_en);

   always @(posedge clock) begin
      if (reset || !mem_req || mem_ack) wait_cnt <= 0;
      else                              wait_cnt <= wait_cnt + 1;
   end

   // ---------------- monitors / scoreboard ----------------
   always @(negedge clock) begin
      if (!reset && mem_req && mem_ack) ack_log.push_back(mem_addr);
   end

   always @(negedge clock) begin
      logic [31:0] got, exp_v;
      if (sb_en && !reset && !redirect && ir_valid && ir_ready) begin
         got = {ir, pc};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got ir=%h pc=%h, required no further entry", ir, pc);
         end else begin
            exp_v = exp_q.pop_front();
            if (got !== exp_v) begin
               errors++;
               $display("FAIL sb_entry: got ir=%h pc=%h, required ir=%h pc=%h",
                        got[31:16], got[15:0], exp_v[31:16], exp_v[15:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset(input int wait_cycles, input logic ready);
      reset        = 1'b1;
      redirect     = 1'b0;
      redirect_pc  = 16'h0000;
      ir_ready     = ready;
      mem_wait     = wait_cycles;
      sb_en        = 1'b0;
      tick();
      tick();
      exp_q.delete();
      ack_log.delete();
      reset = 1'b0;
   endtask

   task automatic expect_range(input logic [15:0] start, input int n);
      logic [15:0] a;
      a = start;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({word_at(a, halt_word_en), a});
         a = a + 16'd2;
      end
   endtask

   // Lets decode drain the expected entries, then stops decode.
   task automatic wait_drain(input int budget, output bit ok);
      ir_ready = 1'b1;
      sb_en    = 1'b1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (exp_q.size() == 0) break;
      end
      ir_ready = 1'b0;
      sb_en    = 1'b0;
      ok = (exp_q.size() == 0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      redirect = 1'b0;
      redirect_pc = 16'h0000;
      ir_ready = 1'b0;
      mem_wait = 0;
      tick();
      tick();
      checks++;
      if ({mem_req, ir_valid, halted} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got req=%b valid=%b halted=%b, required 0 0 0", mem_req, ir_valid, halted);
      end
      checks++;
      if (mem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL reset_addr: got %h, required 0000", mem_addr);
      end
      checks++;
      if (queue_count !== 3'd0 || fsm_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_count_state: got count=%0d state=%0d, required 0 0", queue_count, fsm_state);
      end
   endtask

   task automatic test_stream();
      bit ok;
      apply_reset(0, 1'b1);
      expect_range(16'h0000, 9);
      sb_en = 1'b1;
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || ir_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_edge1: got req=%b addr=%h valid=%b, required 1 0000 0", mem_req, mem_addr, ir_valid);
      end
      tick();
      // Valid after the 2nd edge, so decode samples it at the 3rd.
      checks++;
      if (ir_valid !== 1'b1) begin
         errors++;
         $display("FAIL stream_latency: got ir_valid=%b after edge 2, required 1", ir_valid);
      end
      // One pop per cycle: nine entries need exactly nine more edges.
      for (int i = 0; i < 9; i++) tick();
      sb_en = 1'b0;
      ir_ready = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL stream_rate: got %0d entries left, required 0", exp_q.size());
      end
      ok = 1'b1;
   endtask

   task automatic test_backpressure();
      bit ok;
      apply_reset(0, 1'b0);
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (ack_log.size() != 4) begin
         errors++;
         $display("FAIL bp_req_count: got %0d requests, required 4", ack_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack_log[i] !== 16'(2 * i)) begin
               errors++;
               $display("FAIL bp_req_addr: got %h, required %h", ack_log[i], 16'(2 * i));
            end
         end
      end
      checks++;
      if (queue_count !== 3'd4 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL bp_full: got count=%0d req=%b, required 4 0", queue_count, mem_req);
      end
      expect_range(16'h0000, 8);
      wait_drain(40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_drain: got %0d entries pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_wait_states();
      bit ok;
      apply_reset(3, 1'b1);
      expect_range(16'h0000, 4);
      sb_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== 16'(2 * (k / 4))) begin
            errors++;
            $display("FAIL wait_hold k=%0d: got req=%b addr=%h, required 1 %h", k, mem_req, mem_addr, 16'(2 * (k / 4)));
         end
      end
      wait_drain(10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_order: got %0d entries pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_redirect_pending();
      bit ok;
      apply_reset(3, 1'b0);
      for (int i = 0; i < 14; i++) tick();
      checks++;
      if (mem_addr !== 16'h0006 || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL redir_setup: got req=%b addr=%h, required 1 0006", mem_req, mem_addr);
      end
      redirect    = 1'b1;
      redirect_pc = 16'h0011;
      tick();
      redirect = 1'b0;
      checks++;
      if (queue_count !== 3'd0 || ir_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_flush: got count=%0d valid=%b, required 0 0", queue_count, ir_valid);
      end
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0006 || fsm_state !== 2'd2) begin
         errors++;
         $display("FAIL redir_hold: got req=%b addr=%h state=%0d, required 1 0006 2", mem_req, mem_addr, fsm_state);
      end
      tick();
      tick();
      checks++;
      if (mem_addr !== 16'h0010 || queue_count !== 3'd0) begin
         errors++;
         $display("FAIL redir_next: got addr=%h count=%0d, required 0010 0", mem_addr, queue_count);
      end
      expect_range(16'h0010, 2);
      wait_drain(40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL redir_drain: got %0d entries pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_wrap();
      bit ok;
      apply_reset(0, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      // Memory acks this cycle too, so this fetch is dropped in REQ.
      redirect    = 1'b1;
      redirect_pc = 16'hFFFC;
      tick();
      redirect = 1'b0;
      checks++;
      if (queue_count !== 3'd0 || mem_addr !== 16'hFFFC || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL wrap_redirect: got count=%0d addr=%h req=%b, required 0 fffc 1", queue_count, mem_addr, mem_req);
      end
      expect_range(16'hFFFC, 4);
      wait_drain(20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wrap_order: got %0d entries pending, required 0", exp_q.size());
      end
   endtask

`ifdef INSTR_FETCH_HALT_DETECT_EN
   task automatic test_halt();
      bit ok;
      halt_word_en = 1'b1;
      apply_reset(0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || queue_count !== 3'd3) begin
         errors++;
         $display("FAIL halt_stop: got halted=%b req=%b count=%0d, required 1 0 3", halted, mem_req, queue_count);
      end
      checks++;
      if (ack_log.size() != 3) begin
         errors++;
         $display("FAIL halt_reqs: got %0d requests, required 3", ack_log.size());
      end
      expect_range(16'h0000, 3);
      wait_drain(10, ok);
      checks++;
      if (!ok || halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_drain: got pending=%0d halted=%b, required 0 1", exp_q.size(), halted);
      end
      halt_word_en = 1'b0;
      redirect     = 1'b1;
      redirect_pc  = 16'h0000;
      tick();
      redirect = 1'b0;
      checks++;
      if (halted !== 1'b0 || mem_addr !== 16'h0000 || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL halt_resume: got halted=%b addr=%h req=%b, required 0 0000 1", halted, mem_addr, mem_req);
      end
      expect_range(16'h0000, 2);
      wait_drain(20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL halt_restart: got %0d entries pending, required 0", exp_q.size());
      end
   endtask
`endif

   // ---------------- sequence + report ----------------
   initial begin
      checks       = 0;
      errors       = 0;
      halt_word_en = 1'b0;
      sb_en        = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_wait_states();
      test_redirect_pending();
      test_wrap();
`ifdef INSTR_FETCH_HALT_DETECT_EN
      test_halt();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
